// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that streams the operands one nibble
// per clock through a single 4-bit add-with-carry slice.
// Optional build macro NSA_SUB_EN adds a subtract input (sub) and a signed
// overflow output (ovf).
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one nibble added per clock, LSB nibble first
// DONE  | done pulse; sum/co (and ovf) already hold the new result
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
`ifdef NSA_SUB_EN
  input  logic                   sub,
  output logic                   ovf,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   co
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [W-1:0]    op_a, op_b, res;
  logic [4:0]      nib_sum;
  logic            last_nib;
  logic            sub_c;

`ifdef NSA_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  // The single shared slice always works on the low nibble of the shifting operands
  assign nib_sum  = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'b0, carry};
  assign last_nib = (cnt == CW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, nibble-serial accumulate, publish result on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef NSA_SUB_EN
      ovf   <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub_c ? ~b : b;
            carry <= sub_c ? 1'b1 : ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Operands shift down so the slice always sees nibble cnt; result
          // nibbles enter from the top and land in place after NIBBLES shifts.
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          res   <= {nib_sum[3:0], res[W-1:4]};
          carry <= nib_sum[4];
          cnt   <= cnt + CW'(1);
          if (last_nib) begin
            sum <= {nib_sum[3:0], res[W-1:4]};
            co  <= nib_sum[4];
`ifdef NSA_SUB_EN
            // carry into bit W-1 recovered from the sum bit, XOR carry out
            ovf <= (nib_sum[3] ^ op_a[3] ^ op_b[3]) ^ nib_sum[4];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
